// File: rtl/parallel_division.sv
// PageRank contribution stage: streams (rank, out-degree) pairs through a
// single-cycle array divider and sums the quotients; sticky done after ip_count pairs.
module parallel_division #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] page_rank_bram,
    input  logic [WIDTH-1:0] out_deg_bram,
    input  logic [CNT_W-1:0] ip_count,
    output logic [WIDTH-1:0] final_pagerank,
    output logic             done_parrallel_division
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s1_dividend;
    logic [WIDTH-1:0] s1_divisor;
    logic [WIDTH-1:0] s2_quot;
    logic [WIDTH-1:0] quot;
    logic [2:1]       vld_pipe;

    // Restoring array divider: one compare/subtract row per dividend bit.
    // A zero divisor contributes nothing rather than an all-ones quotient.
    function automatic logic [WIDTH-1:0] array_div(input logic [WIDTH-1:0] n,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   part;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] q;
        rem = '0;
        q   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            part = {rem, n[i]};
            if (part >= {1'b0, d}) begin
                q[i] = 1'b1;
                part = part - {1'b0, d};
            end
            rem = part[WIDTH-1:0];
        end
        return (d == '0) ? '0 : q;
    endfunction

    always_comb quot = array_div(s1_dividend, s1_divisor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= LOAD;
            n_reg                   <= '0;
            cnt                     <= '0;
            s1_dividend             <= '0;
            s1_divisor              <= '0;
            s2_quot                 <= '0;
            vld_pipe                <= '0;
            final_pagerank          <= '0;
            done_parrallel_division <= 1'b0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            vld_pipe[1] <= 1'b0;
            s2_quot     <= quot;
            if (vld_pipe[2])
                final_pagerank <= final_pagerank + s2_quot;
            case (state)
                LOAD: begin
                    if (ip_count == '0) begin
                        done_parrallel_division <= 1'b1;
                        state                   <= DONE;
                    end else begin
                        n_reg       <= ip_count;
                        s1_dividend <= page_rank_bram;
                        s1_divisor  <= out_deg_bram;
                        vld_pipe[1] <= 1'b1;
                        cnt         <= CNT_W'(1);
                        state       <= (ip_count == CNT_W'(1)) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    s1_dividend <= page_rank_bram;
                    s1_divisor  <= out_deg_bram;
                    vld_pipe[1] <= 1'b1;
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == n_reg)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Last pair is the one in stage 2 with nothing behind it.
                    if (vld_pipe[2] && !vld_pipe[1]) begin
                        done_parrallel_division <= 1'b1;
                        state                   <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_parallel_division.sv
// Bench for parallel_division: directed and random runs against an arithmetic model.
module tb_parallel_division;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] page_rank_bram = '0;
    logic [31:0] out_deg_bram = '0;
    logic [3:0]  ip_count = '0;
    logic [31:0] final_pagerank;
    logic        done_parrallel_division;

    int checks = 0;
    int errors = 0;
    logic [31:0] pa [16];
    logic [31:0] pd [16];

    parallel_division #(.WIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .page_rank_bram(page_rank_bram), .out_deg_bram(out_deg_bram),
        .ip_count(ip_count), .final_pagerank(final_pagerank),
        .done_parrallel_division(done_parrallel_division)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sum of quotients of pairs 1..n whose accumulation edge (i+2) is <= e.
    function automatic logic [31:0] model_sum(input int n, input int e);
        logic [31:0] s = '0;
        for (int i = 1; i <= n; i++)
            if (i + 2 <= e)
                s += (pd[i-1] == 0) ? 32'd0 : pa[i-1] / pd[i-1];
        return s;
    endfunction

    function automatic logic model_done(input int n, input int e);
        return (n == 0) ? (e >= 1) : (e >= n + 2);
    endfunction

    task automatic drive_pair(input int idx, input int n);
        if (idx <= n && idx >= 1) begin
            page_rank_bram = pa[idx-1];
            out_deg_bram   = pd[idx-1];
        end else begin
            page_rank_bram = $urandom;
            out_deg_bram   = $urandom;
        end
    endtask

    // Reset pulse, then a full run checked after every edge.
    task automatic run(input string tag, input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_rst_sum"}, final_pagerank, 32'd0);
        check({tag, "_rst_done"}, {31'd0, done_parrallel_division}, 32'd0);
        reset    = 1'b0;
        ip_count = 4'(n);
        drive_pair(1, n);
        for (int e = 1; e <= n + 5; e++) begin
            @(negedge clk);
            check($sformatf("%s_sum_e%0d", tag, e), final_pagerank, model_sum(n, e));
            check($sformatf("%s_done_e%0d", tag, e), {31'd0, done_parrallel_division},
                  {31'd0, model_done(n, e)});
            ip_count = 4'($urandom);
            drive_pair(e + 1, n);
        end
    endtask

    initial begin
        // Reset held with arbitrary inputs.
        for (int c = 0; c < 20; c++) begin
            page_rank_bram = $urandom;
            out_deg_bram   = $urandom;
            ip_count       = 4'($urandom);
            @(negedge clk);
            check("hold_rst_sum", final_pagerank, 32'd0);
            check("hold_rst_done", {31'd0, done_parrallel_division}, 32'd0);
        end

        pa[0] = 15700;  pd[0] = 11;
        pa[1] = 109226; pd[1] = 23;
        pa[2] = 19103;  pd[2] = 109;
        pa[3] = 45507;  pd[3] = 357;
        pa[4] = 6131;   pd[4] = 13;
        pa[5] = 196323; pd[5] = 381;
        pa[6] = 1533;   pd[6] = 41;
        check("golden_model_total", model_sum(7, 9), 32'd7500);
        run("n7", 7);
        check("n7_final", final_pagerank, 32'd7500);

        pa[0] = 100; pd[0] = 0;
        run("div0", 1);

        run("n0", 0);

        pa[0] = 32'hFFFF_FFFF; pd[0] = 1;
        pa[1] = 2;             pd[1] = 1;
        run("wrap", 2);
        check("wrap_final", final_pagerank, 32'd1);

        // Mid-run async reset: assert between edges and look before any edge.
        pa[0] = 15700;  pd[0] = 11;
        pa[1] = 109226; pd[1] = 23;
        pa[2] = 19103;  pd[2] = 109;
        pa[3] = 45507;  pd[3] = 357;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        ip_count = 4'd7;
        drive_pair(1, 7);
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            drive_pair(e + 1, 4);
        end
        check("mid_pre_sum", final_pagerank, model_sum(7, 4));
        #2 reset = 1'b1;
        #1;
        check("mid_async_sum", final_pagerank, 32'd0);
        check("mid_async_done", {31'd0, done_parrallel_division}, 32'd0);
        for (int i = 0; i < 3; i++) begin pa[i] = 10; pd[i] = 3; end
        run("n3", 3);
        check("n3_final", final_pagerank, 32'd9);

        // Random runs, small divisors and occasional zero divisors.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                pa[i] = $urandom;
                case ($urandom_range(0, 3))
                    0: pd[i] = 0;
                    1: pd[i] = $urandom_range(1, 16);
                    2: pd[i] = $urandom;
                    default: pd[i] = $urandom_range(1, 100000);
                endcase
            end
            run($sformatf("rnd%0d", r), n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
